// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester-side bundle for one ram_arbiter port
interface ram_arbiter_if;
  logic        req;
  logic        we;
  logic        bw;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic        err;
  logic [15:0] rdata;

  modport master (output req, we, bw, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, bw, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port arbiter and sequencer for the data RAM
module ram_arbiter #(
  parameter logic [15:0] BOUND_L = 16'h0200,
  parameter logic [15:0] BOUND_U = 16'h0400
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic [15:0]       ram_addr,
  output logic [15:0]       ram_Din,
  output logic              ram_RW,
  output logic              BW,
  input  logic              ram_write_done,
  input  logic [15:0]       ram_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAITW, RESP} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        bw_q, bw_d;
  logic        errf_q, errf_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_din_q, ram_din_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  logic        pick;
  logic        sel_we, sel_bw, sel_bad;
  logic [15:0] sel_addr, sel_wdata, rd_val;

  // Port 0 wins when it is alone or when port 1 was served last.
  assign pick      = !(m0.req && (!m1.req || last_q));
  assign sel_we    = pick ? m1.we    : m0.we;
  assign sel_bw    = pick ? m1.bw    : m0.bw;
  assign sel_addr  = pick ? m1.addr  : m0.addr;
  assign sel_wdata = pick ? m1.wdata : m0.wdata;
  assign sel_bad   = (sel_addr < BOUND_L) || (sel_addr >= BOUND_U) || (!sel_bw && sel_addr[0]);
  assign rd_val    = bw_q ? {8'h00, ram_out[7:0]} : ram_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      bw_q       <= 1'b0;
      errf_q     <= 1'b0;
      ram_addr_q <= 16'h0000;
      ram_din_q  <= 16'h0000;
      rdata0_q   <= 16'h0000;
      rdata1_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      bw_q       <= bw_d;
      errf_q     <= errf_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    bw_d       = bw_q;
    errf_d     = errf_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          gnt_d  = pick;
          we_d   = sel_we;
          bw_d   = sel_bw;
          errf_d = sel_bad;
          if (sel_bad) begin
            state_d = RESP;
          end else begin
            // RAM address/data only move for real accesses, so they hold otherwise.
            ram_addr_d = sel_addr - BOUND_L;
            ram_din_d  = sel_wdata;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = WAITW;
        end else begin
          if (gnt_q) rdata1_d = rd_val;
          else       rdata0_d = rd_val;
          state_d = RESP;
        end
      end
      WAITW: begin
        if (ram_write_done) state_d = RESP;
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_RW   = (state_q == ACCESS) && we_q;
  assign BW       = (state_q == ACCESS) && bw_q;
  assign ram_addr = ram_addr_q;
  assign ram_Din  = ram_din_q;

  assign m0.ack   = (state_q == RESP) && !gnt_q && !errf_q;
  assign m0.err   = (state_q == RESP) && !gnt_q &&  errf_q;
  assign m1.ack   = (state_q == RESP) &&  gnt_q && !errf_q;
  assign m1.err   = (state_q == RESP) &&  gnt_q &&  errf_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 512-byte data RAM (0x0200–0x03FF). Port 0 is the CPU memory stage; port 1 is the DMA/debug engine.
- Grants one requester at a time using round-robin and range/alignment-checks the address.
- Drives the RAM's address, data, RW and BW pins, waits for `ram_write_done` on writes, and returns a one-cycle ack or err with read data.

Parameters:
- BOUND_L, 16'h0200, lowest RAM byte address (inclusive).
- BOUND_U, 16'h0400, RAM upper bound (exclusive).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request, held until m0_ack/m0_err
- m0_we  in  1  port 0 write (1) / read (0)
- m0_bw  in  1  port 0 byte access (1) / word (0)
- m0_addr  in  16  port 0 absolute byte address
- m0_wdata  in  16  port 0 write data (byte in [7:0])
- m0_ack  out  1  port 0 completion pulse
- m0_err  out  1  port 0 error pulse, no RAM access made
- m0_rdata  out  16  port 0 read data, valid with m0_ack
- m1_req, m1_we, m1_bw, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: identical for port 1
- ram_addr  out  16  RAM offset address (absolute − BOUND_L)
- ram_Din  out  16  RAM write data
- ram_RW  out  1  RAM write strobe
- BW  out  1  RAM byte-write select
- ram_write_done  in  1  RAM write completion (registered by RAM)
- ram_out  in  16  RAM combinational read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; m0/m1 ack and err=0; m0/m1 rdata=16'h0000.
  - ram_RW=0, BW=0, ram_addr=0, ram_Din=0; last_grant=1, so port 0 wins the first tie.
  - Reset asserted mid-write drops ram_RW immediately. A RAM write already clocked stands; no ack is issued.
- IDLE state:
  - If exactly one req=1, grant it. If both, grant the port not equal to last_grant.
  - Latch the granted port's we, bw, addr and wdata into internal registers, and record the granted port.
  - Error check: addr < BOUND_L, or addr ≥ BOUND_U, or (bw=0 and addr[0]=1). On error go to RESP with err flag set; otherwise go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS state (one cycle):
  - ram_addr = latched addr − BOUND_L; ram_Din = latched wdata; BW = latched bw.
  - Read: capture rdata = bw ? {8'h00, ram_out[7:0]} : ram_out; go to RESP.
  - Write: ram_RW=1 for this cycle only; go to WAITW.
- WAITW state:
  - ram_RW=0.
  - On ram_write_done=1 go to RESP; otherwise stay. No timeout.
- RESP state (one cycle):
  - Granted port's ack=1 (or err=1 if flagged, never both). Its rdata is held from ACCESS and stays stable until that port's next read.
  - The non-granted port's ack/err stay 0. last_grant ← granted port. Next state IDLE.
- Outside ACCESS: ram_RW=0 and BW=0; ram_addr and ram_Din hold their last driven values.
- Latency, counted from req sampled in IDLE (cycle 0):
  - Read: ack in cycle 2.
  - Write: ack in cycle 3.
  - Error: err in cycle 1.
- Requester handshake rules:
  - Deassert req, or present a new request, at the edge that samples ack/err. The arbiter re-samples req only in IDLE.
  - Requests are not queued; a losing port simply keeps req high.
- Boundary cases:
  - Word at 0x03FE is legal.
  - Byte at 0x03FF is legal.
  - Word at 0x03FF is an error (misaligned).
  - Address 0x0400 is an error.
  - Address 0x01FF is an error.
- A new req arriving while the arbiter is busy waits; the in-flight transfer is never pre-empted.

Test Plan:
- Reset, then m0 word write 0x0200 ← 16'hBEEF, then m0 word read 0x0200 → ram_RW high exactly one cycle with ram_addr=0 and BW=0; m0_ack in cycle 3; read m0_ack in cycle 2 with m0_rdata=16'hBEEF.
- m1 byte write 0x03FF ← 16'h12A5, then byte read 0x03FF → BW=1 during ACCESS, ram_addr=16'h01FF; m1_rdata=16'h00A5.
- m0 and m1 both request reads in the same cycle, repeated for 4 transfers with req held high → grant order 0,1,0,1; no cycle with both acks high.
- Error cases: m0 read at 0x0400, m0 word write at 0x0201, m1 read at 0x01FF → err pulse in cycle 1, ack stays 0, ram_RW never asserted.
- rst_n pulled low during WAITW of an m1 write → outputs return to reset values asynchronously; no m1_ack. After release, an m0 read is granted first (last_grant=1).
- Write to 0x0300 while m1 requests a read of 0x0300 → m1 granted only after m0_ack; m1_rdata returns the newly written value.
